// File: rtl/full_adder_pkg.sv
// Shared constants and result bundle for the full_adder ripple-carry adder.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                    cout;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_res_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell (fa_bit): the leaf of the ripple chain in full_adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Parameterizable ripple-carry adder with combinational and registered results.
// Optional signed-overflow outputs Ovf/Ovf_r are built when FULL_ADDER_OVF_EN is defined.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_r,
  output logic             Cout_r
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             Ovf,
  output logic             Ovf_r
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit u_bit (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (Sum[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[WIDTH];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign sum_d  = Sum;
  assign cout_d = Cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum_r  = sum_q;
  assign Cout_r = cout_q;

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic ovf_d, ovf_q;

  assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf   = ovf_d;
  assign Ovf_r = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1, 4 and 8 (Ovf checks with FULL_ADDER_OVF_EN).
module tb_full_adder;
  import full_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a1, b1, cin1, s1, co1, s1_r, co1_r;
  logic [3:0] a4, b4, s4, s4_r;
  logic       cin4, co4, co4_r;
  logic [7:0] a8, b8, s8, s8_r;
  logic       cin8, co8, co8_r;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf1_r, ovf4, ovf4_r, ovf8, ovf8_r;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1),
    .Sum(s1), .Cout(co1), .Sum_r(s1_r), .Cout_r(co1_r)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ovf1), .Ovf_r(ovf1_r)
`endif
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin4),
    .Sum(s4), .Cout(co4), .Sum_r(s4_r), .Cout_r(co4_r)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ovf4), .Ovf_r(ovf4_r)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8),
    .Sum(s8), .Cout(co8), .Sum_r(s8_r), .Cout_r(co8_r)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ovf8), .Ovf_r(ovf8_r)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];  // {ovf, cout, sum} for the WIDTH=8 registered path

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // WIDTH=1 truth table, indexed by {A,B,Cin}, value {Sum,Cout}.
  logic [1:0] tt[8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  // ---------------- driver tasks ----------------
  task automatic drive_w1(input logic a, input logic b, input logic ci);
    a1 = a; b1 = b; cin1 = ci;
  endtask

  task automatic drive_w4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    a4 = a; b4 = b; cin4 = ci;
  endtask

  task automatic drive_w8_random();
    fa_res_t r;
    logic [8:0] full;
    logic ovf;
    a8   = 8'($urandom_range(0, 255));
    b8   = 8'($urandom_range(0, 255));
    cin8 = 1'($urandom_range(0, 1));
    full = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
    r = '0;
    r.sum  = {56'b0, full[7:0]};
    r.cout = full[8];
    ovf = (a8[7] == b8[7]) && (full[7] != a8[7]);
    exp_q.push_back({ovf, r.cout, r.sum[7:0]});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] e;
    drive_w1(1'b0, 1'b0, 1'b0);
    drive_w4(4'h0, 4'h0, 1'b0);
    a8 = '0; b8 = '0; cin8 = 1'b0;

    // Exhaustive WIDTH=1 sweep while reset is held: comb path ignores rst.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive_w1(v[2], v[1], v[0]);
      #10;
      check($sformatf("w1_sum_%0d", i),  {64'b0, s1},  {64'b0, tt[i][1]});
      check($sformatf("w1_cout_%0d", i), {64'b0, co1}, {64'b0, tt[i][0]});
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w1_ovf_%0d", i), {64'b0, ovf1}, {64'b0, tt[i][0] ^ v[0]});
`endif
    end
    check("w1_sum_r_in_reset", {64'b0, s1_r, co1_r}, 65'd0);
    check("w8_reg_in_reset",   {56'b0, co8_r, s8_r}, 65'd0);

    // Release reset with zero inputs, then apply 1+1+1 and watch the 1-cycle latency.
    @(negedge clk);
    drive_w1(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("w1_reg_zero", {63'b0, s1_r, co1_r}, 65'd0);
    @(negedge clk);
    drive_w1(1'b1, 1'b1, 1'b1);
    #1;
    check("w1_reg_before_edge", {63'b0, s1_r, co1_r}, 65'd0);
    @(posedge clk); #1;
    check("w1_reg_after_edge", {63'b0, s1_r, co1_r}, 65'b11);

    // Reset held over two edges with 1+1+1 applied.
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("w1_reg_rst_%0d", k), {63'b0, s1_r, co1_r}, 65'd0);
      check($sformatf("w1_comb_rst_%0d", k), {63'b0, s1, co1}, 65'b11);
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w1_ovf_r_rst_%0d", k), {64'b0, ovf1_r}, 65'd0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("w1_reg_post_rst", {63'b0, s1_r, co1_r}, 65'b11);

    // WIDTH=4 boundaries.
    @(negedge clk);
    drive_w4(4'hF, 4'h0, 1'b1);
    #1;
    check("w4_wrap", {60'b0, co4, s4}, {60'b0, 5'h10});
    @(posedge clk); #1;
    check("w4_wrap_reg", {60'b0, co4_r, s4_r}, {60'b0, 5'h10});
    @(negedge clk);
    drive_w4(4'hF, 4'hF, 1'b1);
    #1;
    check("w4_all_ones", {60'b0, co4, s4}, {60'b0, 5'h1F});
    drive_w4(4'h0, 4'h0, 1'b0);
    #1;
    check("w4_zero", {60'b0, co4, s4}, 65'd0);
`ifdef FULL_ADDER_OVF_EN
    drive_w4(4'h7, 4'h1, 1'b0);
    #1;
    check("w4_ovf_pos", {60'b0, ovf4, s4}, {60'b0, 5'h18});
    @(posedge clk); #1;
    check("w4_ovf_pos_reg", {64'b0, ovf4_r}, 65'd1);
    @(negedge clk);
    drive_w4(4'h8, 4'hF, 1'b0);
    #1;
    check("w4_ovf_neg", {59'b0, ovf4, co4, s4}, {59'b0, 6'h37});
    drive_w4(4'h3, 4'h2, 1'b0);
    #1;
    check("w4_no_ovf", {64'b0, ovf4}, 65'd0);
`endif

    // WIDTH=8 random vectors: comb checked immediately, registered one edge later.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      drive_w8_random();
      #1;
      e = exp_q[$];
      check("w8_comb", {56'b0, co8, s8}, {56'b0, e[8:0]});
`ifdef FULL_ADDER_OVF_EN
      check("w8_ovf", {64'b0, ovf8}, {64'b0, e[9]});
`endif
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check("w8_queue_empty", 65'd0, 65'd1);
      end else begin
        e = exp_q.pop_front();
        check("w8_reg", {56'b0, co8_r, s8_r}, {56'b0, e[8:0]});
`ifdef FULL_ADDER_OVF_EN
        check("w8_ovf_reg", {64'b0, ovf8_r}, {64'b0, e[9]});
`endif
      end
    end
    check("w8_queue_drained", {33'b0, 32'(exp_q.size())}, 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
